// File: rtl/riscv_debug_ctrl.sv
// Run-control block for a small RISC-V core: halt/run/single-step with one PC breakpoint.
// Optional enabled-cycle counter is built only when DEBUG_CYCLE_COUNT_EN is defined.
module riscv_debug_ctrl #(
    parameter int unsigned PcWidth   = 16,
    parameter int unsigned StepWidth = 16
) (
    input  logic                 Clk,
    input  logic                 RstN,
    input  logic                 CmdValid,
    output logic                 CmdReady,
    input  logic [2:0]           CmdOp,
    input  logic [15:0]          CmdArg,
    input  logic [PcWidth-1:0]   CpuPc,
    output logic                 CpuEn,
    output logic                 Halted,
    output logic                 BpHit,
    output logic [StepWidth-1:0] StepsLeft,
    output logic [31:0]          CycleCount
);

    typedef enum logic [1:0] {StHalt, StRun, StStep, StBreak} state_e;

    localparam logic [2:0] OpHalt  = 3'b000;
    localparam logic [2:0] OpRun   = 3'b001;
    localparam logic [2:0] OpStep  = 3'b010;
    localparam logic [2:0] OpSetBp = 3'b011;
    localparam logic [2:0] OpClrBp = 3'b100;

    state_e               state_q, state_d;
    logic                 ready_q, ready_d;
    logic                 bp_valid_q, bp_valid_d;
    logic [PcWidth-1:0]   bp_addr_q, bp_addr_d;
    logic                 skip_bp_q, skip_bp_d;
    logic [StepWidth-1:0] steps_q, steps_d;

    logic                 accept;
    logic                 running;
    logic                 bpm;
    logic [StepWidth-1:0] step_arg;

    assign accept   = CmdValid & ready_q;
    assign running  = (state_q == StRun) || (state_q == StStep);
    assign bpm      = bp_valid_q & (CpuPc == bp_addr_q) & ~skip_bp_q;
    assign step_arg = StepWidth'(CmdArg);

    assign CpuEn     = running & ~bpm;
    assign Halted    = (state_q == StHalt) || (state_q == StBreak);
    assign BpHit     = (state_q == StBreak);
    assign CmdReady  = ready_q;
    assign StepsLeft = steps_q;

    always_comb begin
        state_d    = state_q;
        steps_d    = steps_q;
        skip_bp_d  = skip_bp_q;
        bp_valid_d = bp_valid_q;
        bp_addr_d  = bp_addr_q;
        ready_d    = ~accept;

        if (CpuEn) begin
            skip_bp_d = 1'b0;
        end

        // A breakpoint hit overrides any run-control command arriving in the same cycle.
        if (running && bpm) begin
            state_d = StBreak;
        end else begin
            if (state_q == StStep && CpuEn) begin
                if (steps_q == StepWidth'(1)) begin
                    state_d = StHalt;
                    steps_d = '0;
                end else begin
                    steps_d = steps_q - StepWidth'(1);
                end
            end
            if (accept) begin
                case (CmdOp)
                    OpHalt: state_d = StHalt;
                    OpRun: begin
                        state_d = StRun;
                        if (!running) skip_bp_d = 1'b1;
                    end
                    OpStep: begin
                        if (step_arg == '0) begin
                            state_d = StHalt;
                            steps_d = '0;
                        end else begin
                            state_d = StStep;
                            steps_d = step_arg;
                            if (!running) skip_bp_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (accept && CmdOp == OpSetBp) begin
            bp_valid_d = 1'b1;
            bp_addr_d  = PcWidth'(CmdArg);
        end
        if (accept && CmdOp == OpClrBp) begin
            bp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q    <= StHalt;
            ready_q    <= 1'b1;
            bp_valid_q <= 1'b0;
            bp_addr_q  <= '0;
            skip_bp_q  <= 1'b0;
            steps_q    <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            bp_valid_q <= bp_valid_d;
            bp_addr_q  <= bp_addr_d;
            skip_bp_q  <= skip_bp_d;
            steps_q    <= steps_d;
        end
    end

`ifdef DEBUG_CYCLE_COUNT_EN
    logic [31:0] cycle_q, cycle_d;

    always_comb begin
        cycle_d = cycle_q;
        if (CpuEn && cycle_q != 32'hFFFF_FFFF) begin
            cycle_d = cycle_q + 32'd1;
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end

    assign CycleCount = cycle_q;
`else
    assign CycleCount = 32'd0;
`endif

endmodule

// File: doc/riscv_debug_ctrl.md
RISCV_DEBUG_CTRL -- requirements
Module: riscv_debug_ctrl

Interface
REQ-001 SHALL have parameter PcWidth, default 16, meaning CPU program-counter width.
REQ-002 SHALL have parameter StepWidth, default 16, meaning step-count register width.
REQ-003 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RstN, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port CmdValid, input, 1, command present.
REQ-006 SHALL have port CmdReady, output, 1, command can be accepted.
REQ-007 SHALL have port CmdOp, input, 3, opcode: 000 HALT, 001 RUN, 010 STEP, 011 SETBP, 100 CLRBP; 101-111 reserved.
REQ-008 SHALL have port CmdArg, input, 16, step count for STEP or breakpoint address for SETBP.
REQ-009 SHALL have port CpuPc, input, PcWidth, current CPU PC.
REQ-010 SHALL have port CpuEn, output, 1, CPU clock-enable; the CPU advances one instruction per cycle with CpuEn=1.
REQ-011 SHALL have port Halted, output, 1, high in HALT or BREAK.
REQ-012 SHALL have port BpHit, output, 1, high in BREAK only.
REQ-013 SHALL have port StepsLeft, output, StepWidth, remaining step count.
REQ-014 SHALL have port CycleCount, output, 32, enabled-cycle count (see Configuration).

Function
REQ-015 SHALL implement states HALT, RUN, STEP, BREAK; Halted=(HALT|BREAK), BpHit=(BREAK).
REQ-016 Command accepted on a rising edge with CmdValid&CmdReady; effect visible the following cycle.
REQ-017 CmdReady SHALL be registered: low for exactly one cycle after each accept, else high (max one command per 2 cycles).
REQ-018 Reserved opcodes SHALL be accepted with no effect.
REQ-019 Breakpoint match bpm = BpValid & (CpuPc==BpAddr) & !SkipBp, combinational.
REQ-020 CpuEn = (RUN|STEP) & !bpm, combinational; CpuEn SHALL be 0 in HALT and BREAK.
REQ-021 In RUN or STEP with bpm=1: next state BREAK; StepsLeft unchanged.
REQ-022 SkipBp SHALL be set when entering RUN or STEP from HALT or BREAK, cleared after the first cycle with CpuEn=1, so execution resumes past a breakpoint PC.
REQ-023 RUN: from any state, next state RUN.
REQ-024 STEP N: N=0 -> next state HALT, StepsLeft=0; N>0 -> next state STEP, StepsLeft=N (reload if already STEP).
REQ-025 In STEP, each cycle with CpuEn=1 SHALL decrement StepsLeft; at StepsLeft=1 with CpuEn=1 next state HALT, StepsLeft=0.
REQ-026 HALT: next state HALT; the accept cycle itself still obeys REQ-020.
REQ-027 SETBP: BpAddr=CmdArg[PcWidth-1:0], BpValid=1 from next cycle, in any state; CLRBP: BpValid=0.
REQ-028 Simultaneous bpm and accepted HALT/RUN/STEP: breakpoint wins, next state BREAK, command discarded; SETBP/CLRBP still applied.
REQ-029 Simultaneous bpm and StepsLeft=1: BREAK, StepsLeft stays 1.
REQ-030 StepsLeft SHALL hold its value in HALT, RUN and BREAK except as set by REQ-024.

Reset
REQ-031 RstN=0 SHALL immediately force: state HALT, CpuEn=0, Halted=1, BpHit=0, CmdReady=1, StepsLeft=0, BpValid=0, BpAddr=0, SkipBp=0, CycleCount=0.
REQ-032 Reset asserted mid-RUN/STEP SHALL drop CpuEn in the same cycle, without waiting for a clock edge; after release the block SHALL sit in HALT until a command arrives.

Configuration
REQ-033 Macro DEBUG_CYCLE_COUNT_EN defined: CycleCount SHALL increment on each cycle with CpuEn=1, saturating at 0xFFFFFFFF, cleared only by reset.
REQ-034 Macro undefined: CycleCount SHALL be constant 0 with no counter logic; all other behaviour identical.

Verification
REQ-035 Reset then RUN, CpuPc counting 0,1,2..., no BP -> CpuEn=1 from cycle after accept; Halted=0; CmdReady low exactly 1 cycle.
REQ-036 STEP 3 from HALT -> CpuEn high exactly 3 cycles, StepsLeft 3,2,1,0, then HALT, Halted=1.
REQ-037 SETBP 0x0004, RUN, PC increments from 0 -> CpuEn=0 at PC=4, BREAK, BpHit=1; then STEP 1 -> one enabled cycle at PC 4, PC=5, HALT.
REQ-038 STEP 5 with BP at PC reached on 2nd step -> BREAK, StepsLeft=4; same-cycle HALT command discarded.
REQ-039 RstN low mid-RUN between edges -> CpuEn, StepsLeft, BpValid zero immediately; with DEBUG_CYCLE_COUNT_EN, CycleCount=0; without, CycleCount always 0.
